// File: rtl/mlp_pkg.sv
// mlp_pkg: shared MLP loader types, frame lengths and slot-index mapping
package mlp_pkg;
  typedef enum logic [1:0] {LOAD, FIRE, WAIT} state_e;
  localparam int FULL_LEN = 28;
  localparam int X_LEN    = 4;
  localparam int HID_BASE = 4;
  localparam int OUT_BASE = 20;
  localparam int CNT_W    = 5;
  // bus slot of hidden weight w_i(4+j)
  function automatic int hid_slot(input int i, input int j);
    return 4 * j + i;
  endfunction
  // frame position of hidden weight w_i(4+j)
  function automatic int hid_word(input int i, input int j);
    return HID_BASE + 4 * j + i;
  endfunction
  // bus slot of output weight w_(4+j)(8+k)
  function automatic int out_slot(input int j, input int k);
    return 4 * k + j;
  endfunction
  // frame position of output weight w_(4+j)(8+k)
  function automatic int out_word(input int j, input int k);
    return OUT_BASE + 4 * k + j;
  endfunction
endpackage

// File: rtl/mlp_stream_loader.sv
// mlp_stream_loader: streams x/weight words into MLP operand buses, launches the core, times out the result
// Optional MLP_LOADER_WEIGHT_HOLD_EN: x-only frames reuse weights retained from the last full frame.
module mlp_stream_loader
  import mlp_pkg::*;
#(
  parameter int WORD_W      = 5,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 s_valid,
  input  logic [WORD_W-1:0]    s_data,
  output logic                 s_ready,
  input  logic                 reload_w,
  output logic [4*WORD_W-1:0]  x_flat,
  output logic [16*WORD_W-1:0] w_hid_flat,
  output logic [8*WORD_W-1:0]  w_out_flat,
  output logic                 in_ready,
  input  logic                 out_done,
  output logic                 busy,
  output logic                 err
);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [TW-1:0]      tmo_q, tmo_d;
  logic               err_q, err_d;
  logic [WORD_W-1:0]  words_q [FULL_LEN];
  logic [WORD_W-1:0]  words_d [FULL_LEN];
  logic               accept, last;
  assign s_ready  = state_q == LOAD && !rst;
  assign in_ready = state_q == FIRE;
  assign busy     = state_q == WAIT;
  assign err      = err_q;
  assign accept   = s_valid && s_ready;
`ifdef MLP_LOADER_WEIGHT_HOLD_EN
  logic wv_q, wv_d, short_q, short_d, short_now;
  // frame kind is decided by reload_w on the first word and held for the rest of the frame
  assign short_now = cnt_q == '0 ? !reload_w && wv_q : short_q;
  assign last      = cnt_q == (short_now ? CNT_W'(X_LEN - 1) : CNT_W'(FULL_LEN - 1));
`else
  logic unused_reload_w;
  assign unused_reload_w = reload_w;
  assign last            = cnt_q == CNT_W'(FULL_LEN - 1);
`endif
  // next-state: load words, one-cycle launch, wait for result or timeout
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tmo_d   = tmo_q;
    err_d   = err_q;
    words_d = words_q;
`ifdef MLP_LOADER_WEIGHT_HOLD_EN
    wv_d    = wv_q;
    short_d = short_q;
`endif
    case (state_q)
      LOAD: if (accept) begin
        words_d[cnt_q] = s_data;
        cnt_d          = last ? '0 : cnt_q + 1'b1;
        state_d        = last ? FIRE : LOAD;
`ifdef MLP_LOADER_WEIGHT_HOLD_EN
        short_d        = short_now;
        wv_d           = wv_q || (last && !short_now);
`endif
      end
      FIRE: begin
        state_d = WAIT;
        tmo_d   = '0;
      end
      WAIT: begin
        state_d = out_done || tmo_q == TW'(TIMEOUT_CYC - 1) ? LOAD : WAIT;
        err_d   = err_q || (!out_done && tmo_q == TW'(TIMEOUT_CYC - 1));
        tmo_d   = tmo_q + 1'b1;
        cnt_d   = '0;
      end
      default: state_d = LOAD;
    endcase
  end
  // state, counters, sticky error and word store
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= LOAD;
      cnt_q   <= '0;
      tmo_q   <= '0;
      err_q   <= 1'b0;
      words_q <= '{default: '0};
`ifdef MLP_LOADER_WEIGHT_HOLD_EN
      wv_q    <= 1'b0;
      short_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
      err_q   <= err_d;
      words_q <= words_d;
`ifdef MLP_LOADER_WEIGHT_HOLD_EN
      wv_q    <= wv_d;
      short_q <= short_d;
`endif
    end
  end
  for (genvar i = 0; i < X_LEN; i++) begin : g_x
    assign x_flat[WORD_W*i +: WORD_W] = words_q[i];
  end
  for (genvar j = 0; j < 4; j++) begin : g_j
    for (genvar i = 0; i < 4; i++) begin : g_hid
      assign w_hid_flat[WORD_W*hid_slot(i, j) +: WORD_W] = words_q[hid_word(i, j)];
    end
    for (genvar k = 0; k < 2; k++) begin : g_out
      assign w_out_flat[WORD_W*out_slot(j, k) +: WORD_W] = words_q[out_word(j, k)];
    end
  end
endmodule

// File: tb/tb_mlp_stream_loader.sv
// tb_mlp_stream_loader: directed checks of the MLP stream loader with a reference MLP core model
module tb_mlp_stream_loader;
  localparam int W = 5;
  logic clk = 0, rst = 1, s_valid = 0, s_ready, reload_w = 1, in_ready, out_done = 0, busy, err;
  logic [W-1:0] s_data = '0;
  logic [4*W-1:0] x_flat;
  logic [16*W-1:0] w_hid_flat;
  logic [8*W-1:0] w_out_flat;
  int checks = 0, errors = 0;
  logic [4*W-1:0] ex;
  logic [16*W-1:0] eh;
  logic [8*W-1:0] eo;
  int f1 [28] = '{4, 2, 4, 1, 3, 2, 13, -6, -9, 1, -4, 14, 3, 6, -15, 15,
                  9, -10, 15, -10, 0, -1, 3, -11, -12, -15, -15, 6};
  int fm16 [28] = '{default: -16};
  int f15 [28] = '{default: 15};
  mlp_stream_loader dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .reload_w(reload_w), .x_flat(x_flat), .w_hid_flat(w_hid_flat), .w_out_flat(w_out_flat),
    .in_ready(in_ready), .out_done(out_done), .busy(busy), .err(err)
  );
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic send(input int f [28], input int n, input bit bubble, input bit rl);
    for (int i = 0; i < n; i++) begin
      if (bubble) begin
        s_valid = 0;
        s_data  = 5'h1f;
        tick();
      end
      s_valid  = 1;
      s_data   = W'(f[i]);
      reload_w = rl;
      tick();
    end
    s_valid = 0;
  endtask
  task automatic build(input int f [28]);
    for (int i = 0; i < 4; i++) ex[W*i +: W] = W'(f[i]);
    for (int j = 0; j < 4; j++) begin
      for (int i = 0; i < 4; i++) eh[W*(4*j+i) +: W] = W'(f[4 + 4*j + i]);
      for (int k = 0; k < 2; k++) eo[W*(4*k+j) +: W] = W'(f[20 + 4*k + j]);
    end
  endtask
  function automatic int core(input int k);
    int hs [4];
    int s;
    for (int j = 0; j < 4; j++) begin
      s = 0;
      for (int i = 0; i < 4; i++) s += $signed(x_flat[W*i +: W]) * $signed(w_hid_flat[W*(4*j+i) +: W]);
      hs[j] = s < 0 ? 0 : s;
    end
    s = 0;
    for (int j = 0; j < 4; j++) s += hs[j] * $signed(w_out_flat[W*(4*k+j) +: W]);
    return s;
  endfunction
  task automatic finish_handshake;
    out_done = 1;
    tick();
    tick();
    out_done = 0;
  endtask
  initial begin
    tick();
    tick();
    chk("rst_s_ready", s_ready, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    chk("rst_x", x_flat, 0);
    chk("rst_hid", w_hid_flat, 0);
    chk("rst_out", w_out_flat, 0);
    rst = 0;
    #1;
    chk("post_rst_s_ready", s_ready, 1);
    build(f1);
    send(f1, 28, 0, 1);
    chk("t1_in_ready", in_ready, 1);
    chk("t1_s_ready_fire", s_ready, 0);
    chk("t1_x", x_flat, ex);
    chk("t1_hid", w_hid_flat, eh);
    chk("t1_out", w_out_flat, eo);
    chk("t1_out0", core(0), -726);
    chk("t1_out1", core(1), -348);
    tick();
    chk("t1_pulse_end", in_ready, 0);
    chk("t1_busy", busy, 1);
    chk("t1_s_ready_wait", s_ready, 0);
    out_done = 1;
    tick();
    out_done = 0;
    chk("t1_done_busy", busy, 0);
    chk("t1_done_s_ready", s_ready, 1);
    send(f1, 27, 1, 1);
    s_valid = 0;
    s_data  = 5'h1f;
    tick();
    chk("t2_no_early_fire", in_ready, 0);
    s_valid = 1;
    s_data  = W'(f1[27]);
    tick();
    s_valid = 0;
    chk("t2_in_ready", in_ready, 1);
    chk("t2_x", x_flat, ex);
    chk("t2_hid", w_hid_flat, eh);
    chk("t2_out", w_out_flat, eo);
    out_done = 1;
    tick();
    chk("t2_premature_busy", busy, 1);
    chk("t2_premature_in_ready", in_ready, 0);
    tick();
    out_done = 0;
    chk("t2_done_busy", busy, 0);
    chk("t2_done_s_ready", s_ready, 1);
    send(f1, 28, 0, 1);
    tick();
    repeat (15) tick();
    chk("t3_err_before", err, 0);
    chk("t3_busy_before", busy, 1);
    chk("t3_x_held", x_flat, ex);
    tick();
    chk("t3_err", err, 1);
    chk("t3_busy_after", busy, 0);
    chk("t3_s_ready", s_ready, 1);
    send(f1, 10, 0, 1);
    chk("t4_err_sticky", err, 1);
    rst = 1;
    tick();
    chk("t4_rst_s_ready", s_ready, 0);
    chk("t4_rst_err", err, 0);
    chk("t4_rst_x", x_flat, 0);
    rst = 0;
    build(fm16);
    send(fm16, 28, 0, 1);
    chk("t4_in_ready", in_ready, 1);
    chk("t4_x", x_flat, 20'h84210);
    chk("t4_hid", w_hid_flat, eh);
    chk("t4_out0", core(0), -65536);
    chk("t4_out1", core(1), -65536);
    finish_handshake();
`ifdef MLP_LOADER_WEIGHT_HOLD_EN
    build(f15);
    send(f15, 28, 0, 1);
    chk("t5_full_in_ready", in_ready, 1);
    finish_handshake();
    send(f15, 4, 0, 0);
    chk("t5_xonly_in_ready", in_ready, 1);
    chk("t5_x", x_flat, ex);
    chk("t5_hid_kept", w_hid_flat, eh);
    chk("t5_out_kept", w_out_flat, eo);
    chk("t5_out0", core(0), 54000);
    chk("t5_out1", core(1), 54000);
    finish_handshake();
`else
    build(f15);
    send(f15, 4, 0, 0);
    chk("t5_no_short_frame", in_ready, 0);
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mlp_stream_loader.md
MLP_STREAM_LOADER -- requirements
Module: mlp_stream_loader

Interface
REQ-001 SHALL have parameter WORD_W, default 5, meaning operand width: signed two's complement x and w words.
REQ-002 SHALL have parameter TIMEOUT_CYC, default 16, meaning maximum cycles from in_ready to out_done.
REQ-003 SHALL have ports, one per line (name, direction, width, meaning):
- clk  input  1  sole clock, rising edge
- rst  input  1  reset, synchronous, active-high
- s_valid  input  1  stream word valid
- s_data  input  WORD_W  stream word
- s_ready  output  1  loader accepts a word
- reload_w  input  1  frame carries weights; sampled with the frame's first word
- x_flat  output  4*WORD_W  x0..x3 to the MLP core
- w_hid_flat  output  16*WORD_W  hidden-layer weights w04..w37
- w_out_flat  output  8*WORD_W  output-layer weights w48..w79
- in_ready  output  1  one-cycle launch pulse to the MLP core
- out_done  input  1  core's out0_ready AND out1_ready
- busy  output  1  frame launched, result not yet returned
- err  output  1  sticky timeout flag

Function
REQ-004 SHALL accept a word only on a cycle where s_valid and s_ready are both 1.
REQ-005 SHALL use full-frame order x0,x1,x2,x3, w04,w14,w24,w34, w05..w35, w06..w36, w07..w37, w48,w58,w68,w78, w49,w59,w69,w79: 28 words.
REQ-006 SHALL pack xi at x_flat[5i+4:5i], w_i(4+j) at w_hid_flat slot 4j+i, and w_(4+j)(8+k) at w_out_flat slot 4k+j; slot n occupies bits [5n+4:5n] for WORD_W=5.
REQ-007 SHALL implement states LOAD, FIRE, WAIT; reset enters LOAD.
REQ-008 SHALL, in LOAD, drive s_ready=1, write each accepted word into its slot, and increment a word counter.
REQ-009 SHALL transition LOAD->FIRE on the cycle the last word of the frame is accepted; idle s_valid cycles (bubbles) SHALL stall the counter without penalty.
REQ-010 SHALL, in FIRE, drive in_ready=1 for exactly one cycle and s_ready=0, then enter WAIT.
REQ-011 SHALL, in WAIT, drive s_ready=0 and busy=1; out_done=1 returns to LOAD with the counter cleared.
REQ-012 SHALL count WAIT cycles; reaching TIMEOUT_CYC without out_done SHALL set err=1 and return to LOAD.
REQ-013 SHALL hold x_flat, w_hid_flat and w_out_flat constant outside LOAD.
REQ-014 SHALL treat out_done=1 in FIRE as premature: ignore it and still enter WAIT.
REQ-015 SHALL clear err only on rst.

Reset
REQ-016 SHALL, with rst=1 at a clk edge, force state LOAD, counter 0, all flat buses 0, s_ready=0 during reset, in_ready=0, busy=0, err=0, weights_valid=0.
REQ-017 SHALL discard a partially loaded frame on rst mid-LOAD; the next accepted word is x0.

Configuration
REQ-018 SHALL honour macro MLP_LOADER_WEIGHT_HOLD_EN; when defined, a frame whose first word has reload_w=0 while weights_valid=1 SHALL be x-only (4 words x0..x3), with retained weights launched in FIRE; weights_valid SHALL set after the first full frame.
REQ-019 SHALL, without MLP_LOADER_WEIGHT_HOLD_EN, ignore reload_w, omit weights_valid, and require 28 words per frame.

Structure
REQ-020 SHALL place the state enum, frame-length constants (28, 4) and slot-index mapping in shared package mlp_pkg, reused by top and benches.
REQ-021 SHALL contain no sub-module; the timeout counter is inline.

Verification
REQ-022 Full frame, x=4,2,4,1, w04..w79 = 3,2,13,-6,-9,1,-4,14,3,6,-15,15,9,-10,15,-10,0,-1,3,-11,-12,-15,-15,6, s_valid constant -> in_ready one cycle after 28th accept; MLP core gives out0=-726, out1=-348.
REQ-023 Same frame with s_valid=0 every other cycle -> identical buses; in_ready delayed only by bubbles.
REQ-024 out_done held 0 after launch -> err=1 at TIMEOUT_CYC=16 WAIT cycles, state LOAD, s_ready=1 next cycle.
REQ-025 rst after word 10 then a full all -16 frame -> x_flat all 5'b10000, core gives out0=out1=-65536.
REQ-026 With MLP_LOADER_WEIGHT_HOLD_EN: all-15 full frame, then x-only frame x=15 with reload_w=0 -> in_ready after 4 accepts, weights unchanged, core gives out0=out1=54000.
